// File: rtl/diff_phase_avg_if.sv
`default_nettype none
// ============================================================================
//  Module   : diff_phase_avg_if
//  Purpose  : Bundle of sample-strobe inputs, six phase-difference inputs and
//             the averaged-result valid/ready stream of diff_phase_avg.
//  Revision : 1.0 - initial release
// ============================================================================
interface diff_phase_avg_if #(
  parameter int LOG2_N = 4
) ();
  logic                    enable;
  logic                    clear;
  logic [5:0][15:0]        diff_phase;
  logic [5:0][15:0]        avg_phase;
  logic                    avg_valid;
  logic                    avg_ready;
  logic                    overrun;
  logic [LOG2_N-1:0]       win_count;

  // Averager side: consumes samples, produces the averaged stream
  modport master (
    input  enable, clear, diff_phase, avg_ready,
    output avg_phase, avg_valid, overrun, win_count
  );

  // Environment side: drives samples, consumes the averaged stream
  modport slave (
    output enable, clear, diff_phase, avg_ready,
    input  avg_phase, avg_valid, overrun, win_count
  );
endinterface
`default_nettype wire

// File: rtl/diff_phase_avg.sv
`default_nettype none
// ============================================================================
//  Module   : diff_phase_avg
//  Purpose  : Windowed mean of six signed inter-hydrophone phase differences.
//             The enable strobe is delayed by LATENCY cycles to line up with
//             the upstream pipeline; every 2^LOG2_N captured samples one
//             averaged set is offered on a valid/ready stream, with a sticky
//             overrun flag when an unaccepted set is overwritten.
//  Options  : DIFF_PHASE_UNWRAP_EN - wrap-aware averaging around a per-window
//             reference sample (mean stays correct across the +/-pi seam).
//  Revision : 1.0 - initial release
// ============================================================================
module diff_phase_avg #(
  parameter int LOG2_N  = 4,
  parameter int LATENCY = 4
) (
  input  wire logic          clock,
  input  wire logic          reset,
  diff_phase_avg_if.master   io_bus
);

  localparam int c_AW = 16 + LOG2_N;
  localparam int c_CH = 6;

  logic [LATENCY-1:0] r_dly;
  logic               w_smp;
  logic [LOG2_N-1:0]  r_win;
  logic               r_done;
  logic               w_first;
  logic               w_last;
  logic [15:0]        w_avg [c_CH];
  logic [15:0]        r_avg [c_CH];
  logic               r_valid;
  logic               r_ovr;

  // --------------------------------------------------------------------------
  // Strobe delay line: smp is enable delayed by LATENCY cycles
  // --------------------------------------------------------------------------
  generate
    if (LATENCY == 1) begin : g_dly_single
      // Single-stage delay of the sample strobe
      always_ff @(posedge clock or negedge reset) begin
        if (!reset)            r_dly <= '0;
        else if (io_bus.clear) r_dly <= '0;
        else                   r_dly <= io_bus.enable;
      end
    end else begin : g_dly_multi
      // Multi-stage shift of the sample strobe
      always_ff @(posedge clock or negedge reset) begin
        if (!reset)            r_dly <= '0;
        else if (io_bus.clear) r_dly <= '0;
        else                   r_dly <= {r_dly[LATENCY-2:0], io_bus.enable};
      end
    end
  endgenerate

  assign w_smp   = r_dly[LATENCY-1];
  assign w_first = (r_win == '0);
  assign w_last  = &r_win;

  // Window counter; wraps naturally at N-1 and raises done for one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_win  <= '0;
      r_done <= 1'b0;
    end else if (io_bus.clear) begin
      r_win  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_smp & w_last;
      if (w_smp) r_win <= r_win + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel accumulators. The first sample of a window reloads the
  // accumulator, so a new window may start on the same edge that finalise
  // reads the completed sum.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < c_CH; gi++) begin : g_ch
      logic [15:0]     w_x;
      logic [c_AW-1:0] r_acc;

      assign w_x = io_bus.diff_phase[gi];

`ifdef DIFF_PHASE_UNWRAP_EN
      logic [15:0] r_ref;
      logic [15:0] w_dev;

      // Deviation from the window reference, wrapped to a signed 16-bit value
      assign w_dev = w_x - r_ref;

      // Reference capture on the first sample, deviation sum afterwards
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_acc <= '0;
          r_ref <= '0;
        end else if (io_bus.clear) begin
          r_acc <= '0;
          r_ref <= '0;
        end else if (w_smp) begin
          if (w_first) begin
            r_ref <= w_x;
            r_acc <= '0;
          end else begin
            r_acc <= r_acc + {{LOG2_N{w_dev[15]}}, w_dev};
          end
        end
      end

      // Reference plus floored mean deviation, modulo 2^16
      assign w_avg[gi] = r_ref + r_acc[LOG2_N +: 16];
`else
      // Plain sign-extended sum of the raw samples
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_acc <= '0;
        end else if (io_bus.clear) begin
          r_acc <= '0;
        end else if (w_smp) begin
          if (w_first) r_acc <= {{LOG2_N{w_x[15]}}, w_x};
          else         r_acc <= r_acc + {{LOG2_N{w_x[15]}}, w_x};
        end
      end

      // Taking the upper 16 bits is an arithmetic shift: floors toward -inf
      assign w_avg[gi] = r_acc[LOG2_N +: 16];
`endif

      assign io_bus.avg_phase[gi] = r_avg[gi];
    end
  endgenerate

  // Finalise and valid/ready handshake; a new set always wins over the old
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_CH; i++) r_avg[i] <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (io_bus.clear) begin
      for (int i = 0; i < c_CH; i++) r_avg[i] <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (r_done) begin
      for (int i = 0; i < c_CH; i++) r_avg[i] <= w_avg[i];
      r_valid <= 1'b1;
      if (r_valid && !io_bus.avg_ready) r_ovr <= 1'b1;
    end else if (r_valid && io_bus.avg_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign io_bus.avg_valid = r_valid;
  assign io_bus.overrun   = r_ovr;
  assign io_bus.win_count = r_win;

endmodule
`default_nettype wire
